// File: rtl/pll_reset_sequencer.sv
// pll_reset_sequencer
// Synchronises the PLL lock flag, waits for a programmable stable-lock time,
// then releases NUM_RESETS active-high domain resets one at a time, spaced
// RELEASE_GAP cycles apart. Loss of lock or a software request re-asserts
// every reset; lock losses after the first release are counted (saturating).

module pll_reset_sequencer #(
   parameter int unsigned NUM_RESETS         = 4,
   parameter int unsigned LOCK_STABLE_CYCLES = 1024,
   parameter int unsigned RELEASE_GAP        = 16,
   parameter int unsigned SYNC_STAGES        = 2,
   parameter int unsigned LOSS_COUNT_WIDTH   = 8
) (
   input  logic                        clock,
   input  logic                        reset,
   input  logic                        pll_locked,
   input  logic                        force_reset,
   output logic [NUM_RESETS-1:0]       reset_out,
   output logic                        all_released,
   output logic [LOSS_COUNT_WIDTH-1:0] lock_loss_count,
   output logic [1:0]                  seq_state
);

   // Counter widths sized to hold their terminal values without wrapping.
   localparam int unsigned STAB_W = $clog2(LOCK_STABLE_CYCLES + 1);
   localparam int unsigned GAP_W  = $clog2(RELEASE_GAP + 1);
   localparam int unsigned IDX_W  = (NUM_RESETS > 1) ? $clog2(NUM_RESETS) : 1;

   localparam logic [STAB_W-1:0] STAB_LAST = STAB_W'(LOCK_STABLE_CYCLES);
   localparam logic [GAP_W-1:0]  GAP_LAST  = GAP_W'(RELEASE_GAP);
   localparam logic [IDX_W-1:0]  IDX_LAST  = IDX_W'(NUM_RESETS - 1);

   typedef enum logic [1:0] {
      ST_HOLD    = 2'd0,
      ST_STABLE  = 2'd1,
      ST_RELEASE = 2'd2,
      ST_RUN     = 2'd3
   } state_t;

   logic [SYNC_STAGES-1:0]      sync_q;
   logic                        lock_s;

   state_t                      state_q, state_d;
   logic [STAB_W-1:0]           stab_q, stab_d;
   logic [GAP_W-1:0]            gap_q, gap_d;
   logic [IDX_W-1:0]            idx_q, idx_d;
   logic [NUM_RESETS-1:0]       rst_q, rst_d;
   logic [LOSS_COUNT_WIDTH-1:0] loss_q, loss_d;
   logic                        all_rel_q, all_rel_d;
   logic                        start_rel;
   logic                        lost;

   // Metastability synchroniser for the asynchronous PLL lock flag.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         sync_q <= '0;
      end else begin
         sync_q <= {sync_q[SYNC_STAGES-2:0], pll_locked};
      end
   end

   assign lock_s = sync_q[SYNC_STAGES-1];

   // Sequencer state and all registered outputs.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_q   <= ST_HOLD;
         stab_q    <= '0;
         gap_q     <= '0;
         idx_q     <= '0;
         rst_q     <= '1;
         loss_q    <= '0;
         all_rel_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         stab_q    <= stab_d;
         gap_q     <= gap_d;
         idx_q     <= idx_d;
         rst_q     <= rst_d;
         loss_q    <= loss_d;
         all_rel_q <= all_rel_d;
      end
   end

   // Next-state logic: lock qualification, staged release, loss and force handling.
   always_comb begin
      state_d   = state_q;
      stab_d    = stab_q;
      gap_d     = gap_q;
      idx_d     = idx_q;
      rst_d     = rst_q;
      loss_d    = loss_q;
      start_rel = 1'b0;
      lost      = 1'b0;

      case (state_q)
         ST_HOLD: begin
            rst_d  = '1;
            stab_d = '0;
            gap_d  = '0;
            idx_d  = '0;
            if (lock_s) begin
               // The first synchronised lock cycle already counts as one.
               if (STAB_LAST == STAB_W'(1)) begin
                  start_rel = 1'b1;
               end else begin
                  state_d = ST_STABLE;
                  stab_d  = STAB_W'(1);
               end
            end
         end

         ST_STABLE: begin
            if (!lock_s) begin
               // Lock never qualified, so this is not a counted loss.
               state_d = ST_HOLD;
               stab_d  = '0;
            end else if (stab_q + STAB_W'(1) == STAB_LAST) begin
               start_rel = 1'b1;
            end else begin
               stab_d = stab_q + STAB_W'(1);
            end
         end

         ST_RELEASE: begin
            if (!lock_s) begin
               lost = 1'b1;
            end else if (gap_q + GAP_W'(1) == GAP_LAST) begin
               // Only ever clears bits, so releases stay monotonic.
               rst_d = rst_q & ~(NUM_RESETS'(1) << idx_q);
               gap_d = '0;
               if (idx_q == IDX_LAST) begin
                  state_d = ST_RUN;
               end else begin
                  idx_d = idx_q + IDX_W'(1);
               end
            end else begin
               gap_d = gap_q + GAP_W'(1);
            end
         end

         ST_RUN: begin
            rst_d = '0;
            if (!lock_s) begin
               lost = 1'b1;
            end
         end

         default: begin
            state_d = ST_HOLD;
         end
      endcase

      // Lock qualified: drop bit 0 and start spacing out the rest.
      if (start_rel) begin
         rst_d    = '1;
         rst_d[0] = 1'b0;
         stab_d   = '0;
         gap_d    = '0;
         idx_d    = IDX_W'(1);
         state_d  = (NUM_RESETS == 1) ? ST_RUN : ST_RELEASE;
      end

      // Lock dropped after release began: re-assert everything and count it.
      if (lost) begin
         state_d = ST_HOLD;
         rst_d   = '1;
         stab_d  = '0;
         gap_d   = '0;
         idx_d   = '0;
         if (loss_q != '1) begin
            loss_d = loss_q + LOSS_COUNT_WIDTH'(1);
         end
      end

      // Software request overrides lock status and is never counted as a loss.
      if (force_reset) begin
         state_d = ST_HOLD;
         rst_d   = '1;
         stab_d  = '0;
         gap_d   = '0;
         idx_d   = '0;
         loss_d  = loss_q;
      end

      all_rel_d = (rst_d == '0);
   end

   assign reset_out       = rst_q;
   assign all_released    = all_rel_q;
   assign lock_loss_count = loss_q;
   assign seq_state       = state_q;

endmodule

// File: tb/tb_pll_reset_sequencer.sv
// Directed testbench for pll_reset_sequencer (NUM_RESETS=3, stable=8, gap=4,
// two sync stages, 2-bit loss counter). Inputs change and outputs are
// sampled on the falling edge; edge numbers refer to rising edges.

module tb_pll_reset_sequencer;

   localparam int unsigned NR  = 3;
   localparam int unsigned LSC = 8;
   localparam int unsigned GAP = 4;
   localparam int unsigned SS  = 2;
   localparam int unsigned LW  = 2;

   logic          clock = 1'b0;
   logic          reset;
   logic          pll_locked;
   logic          force_reset;
   logic [NR-1:0] reset_out;
   logic          all_released;
   logic [LW-1:0] lock_loss_count;
   logic [1:0]    seq_state;

   int n_cmp = 0;
   int n_err = 0;

   pll_reset_sequencer #(
      .NUM_RESETS         (NR),
      .LOCK_STABLE_CYCLES (LSC),
      .RELEASE_GAP        (GAP),
      .SYNC_STAGES        (SS),
      .LOSS_COUNT_WIDTH   (LW)
   ) dut (
      .clock           (clock),
      .reset           (reset),
      .pll_locked      (pll_locked),
      .force_reset     (force_reset),
      .reset_out       (reset_out),
      .all_released    (all_released),
      .lock_loss_count (lock_loss_count),
      .seq_state       (seq_state)
   );

   always #5 clock = ~clock;

   // Single comparison point: counts and reports.
   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Advance n rising edges, then stop at the following falling edge.
   task automatic adv(input int n);
      repeat (n) @(posedge clock);
      @(negedge clock);
   endtask

   task automatic check_out(input string tag, input int exp_rst, input int exp_all, input int exp_st);
      check({tag, ".rst"}, 32'(reset_out), 32'(exp_rst));
      check({tag, ".all"}, 32'(all_released), 32'(exp_all));
      check({tag, ".st"}, 32'(seq_state), 32'(exp_st));
   endtask

   task automatic check_loss(input string tag, input int exp_cnt);
      check({tag, ".loss"}, 32'(lock_loss_count), 32'(exp_cnt));
   endtask

   // Lock is already high and the next rising edge is edge 1.
   // Releases expected after edges 10, 14 and 18.
   task automatic release_seq(input string tag);
      adv(9);
      check_out({tag, ".e9"}, 7, 0, 1);
      adv(1);
      check_out({tag, ".e10"}, 6, 0, 2);
      adv(3);
      check_out({tag, ".e13"}, 6, 0, 2);
      adv(1);
      check_out({tag, ".e14"}, 4, 0, 2);
      adv(3);
      check_out({tag, ".e17"}, 4, 0, 2);
      adv(1);
      check_out({tag, ".e18"}, 0, 1, 3);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      reset       = 1'b1;
      pll_locked  = 1'b0;
      force_reset = 1'b0;

      // Reset values, before and across clock edges
      #1;
      check_out("por", 7, 0, 0);
      check_loss("por", 0);
      adv(3);
      check_out("por_clk", 7, 0, 0);

      // Basic sequence: lock high before edge 1
      reset      = 1'b0;
      pll_locked = 1'b1;
      release_seq("seq1");
      check_loss("seq1", 0);

      // Lock loss from RUN: sampled low at edge m, resets high after m+2
      pll_locked = 1'b0;
      adv(2);
      check_out("loss.m1", 0, 1, 3);
      adv(1);
      check_out("loss.m2", 7, 0, 0);
      check_loss("loss.m2", 1);
      pll_locked = 1'b1;
      release_seq("relock");
      check_loss("relock", 1);

      // Saturation of the 2-bit loss counter over events 2..5
      for (int i = 2; i <= 5; i++) begin
         pll_locked = 1'b0;
         adv(3);
         check_loss($sformatf("sat%0d", i), (i > 3) ? 3 : i);
         check($sformatf("sat%0d.rst", i), 32'(reset_out), 32'd7);
         pll_locked = 1'b1;
         adv(18);
         check($sformatf("sat%0d.run", i), 32'(reset_out), 32'd0);
      end

      // force_reset from RUN, held for three edges, lock stays high
      force_reset = 1'b1;
      adv(1);
      check_out("force.f1", 7, 0, 0);
      check_loss("force.f1", 3);
      adv(2);
      check_out("force.held", 7, 0, 0);
      force_reset = 1'b0;
      adv(7);
      check_out("force.p7", 7, 0, 1);
      adv(1);
      check_out("force.p8", 6, 0, 2);
      adv(4);
      check_out("force.p12", 4, 0, 2);
      adv(4);
      check_out("force.p16", 0, 1, 3);
      check_loss("force.end", 3);

      // Asynchronous reset in the middle of RELEASE
      pll_locked = 1'b0;
      adv(3);
      pll_locked = 1'b1;
      adv(14);
      check_out("arst.pre", 4, 0, 2);
      reset = 1'b1;
      #1;
      check_out("arst.now", 7, 0, 0);
      check_loss("arst.now", 0);
      adv(2);
      reset = 1'b0;
      release_seq("arst.seq");

      // One-cycle lock glitch sampled at edge 6 restarts qualification
      reset      = 1'b1;
      pll_locked = 1'b0;
      adv(2);
      reset      = 1'b0;
      pll_locked = 1'b1;
      adv(5);
      pll_locked = 1'b0;
      adv(1);
      pll_locked = 1'b1;
      check_out("glitch.e6", 7, 0, 1);
      adv(2);
      check_out("glitch.e8", 7, 0, 0);
      adv(1);
      check_out("glitch.e9", 7, 0, 1);
      adv(6);
      check_out("glitch.e15", 7, 0, 1);
      adv(1);
      check_out("glitch.e16", 6, 0, 2);
      adv(4);
      check_out("glitch.e20", 4, 0, 2);
      adv(4);
      check_out("glitch.e24", 0, 1, 3);
      check_loss("glitch", 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
